// File: rtl/sm_ingress_narrow_adapter_pkg.sv
// Shared types and width helpers for the string-matcher ingress narrowing adapter.
package sm_ingress_narrow_adapter_pkg;
  localparam int META_WIDTH = 32;

  typedef logic [META_WIDTH-1:0] metadata_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_e;

  // Width of an empty-byte count for a bus of the given bit width (never below 1).
  function automatic int empty_w(input int width);
    return (width / 8 > 1) ? $clog2(width / 8) : 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sm_ingress_narrow_adapter_if.sv
// Packet/meta ingress and narrowed egress bundle of the ingress adapter.
interface sm_ingress_narrow_adapter_if
  import sm_ingress_narrow_adapter_pkg::*;
#(
  parameter int IN_WIDTH   = 512,
  parameter int OUT_WIDTH  = 256,
  parameter int META_WIDTH = sm_ingress_narrow_adapter_pkg::META_WIDTH
);
  localparam int IEW = empty_w(IN_WIDTH);
  localparam int OEW = empty_w(OUT_WIDTH);

  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_valid, in_sop, in_eop;
  logic [IEW-1:0]        in_empty;
  logic                  in_ready;
  logic [META_WIDTH-1:0] in_meta_data;
  logic                  in_meta_valid, in_meta_ready;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_valid, out_sop, out_eop;
  logic [OEW-1:0]        out_empty;
  logic                  out_ready;
  logic [META_WIDTH-1:0] out_meta_data;
  logic                  out_meta_valid;

  modport slave (
    input  in_data, in_valid, in_sop, in_eop, in_empty, in_meta_data, in_meta_valid, out_ready,
    output in_ready, in_meta_ready, out_data, out_valid, out_sop, out_eop, out_empty,
           out_meta_data, out_meta_valid
  );

  modport master (
    output in_data, in_valid, in_sop, in_eop, in_empty, in_meta_data, in_meta_valid, out_ready,
    input  in_ready, in_meta_ready, out_data, out_valid, out_sop, out_eop, out_empty,
           out_meta_data, out_meta_valid
  );
endinterface

// File: rtl/sm_ingress_narrow_adapter_slicer.sv
// Lane mux for a buffered wide beat plus last-lane and output-empty derivation.
module sm_lane_slicer
  import sm_ingress_narrow_adapter_pkg::*;
#(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 256
) (
  input  logic [IN_WIDTH-1:0]                 i_data,
  input  logic                                i_eop,
  input  logic [empty_w(IN_WIDTH)-1:0]        i_empty,
  input  logic [idx_w(IN_WIDTH/OUT_WIDTH)-1:0] i_lane,
  output logic [OUT_WIDTH-1:0]                o_data,
  output logic [idx_w(IN_WIDTH/OUT_WIDTH)-1:0] o_last,
  output logic [empty_w(OUT_WIDTH)-1:0]       o_empty
);
  localparam int R   = IN_WIDTH / OUT_WIDTH;
  localparam int IB  = IN_WIDTH / 8;
  localparam int OB  = OUT_WIDTH / 8;
  localparam int LW  = idx_w(R);
  localparam int OEW = empty_w(OUT_WIDTH);

  logic [R-1:0][OUT_WIDTH-1:0] w_lanes;
  int w_bytes, w_last;

  assign w_lanes = i_data;

  // Valid bytes of the beat decide how many lanes carry data; the tail lane pads the rest.
  always_comb begin
    w_bytes = i_eop ? IB - int'(i_empty) : IB;
    w_last  = (w_bytes - 1) / OB;
  end

  assign o_last  = LW'(w_last);
  assign o_empty = OEW'((w_last + 1) * OB - w_bytes);
  assign o_data  = w_lanes[LW'(R - 1) - i_lane];
endmodule

// File: rtl/sm_ingress_narrow_adapter.sv
// Narrows a wide packet stream to output lanes, pairs one meta word per packet, enforces an eop gap.
module sm_ingress_narrow_adapter #(
  parameter int IN_WIDTH   = 512,
  parameter int OUT_WIDTH  = 256,
  parameter int META_WIDTH = sm_ingress_narrow_adapter_pkg::META_WIDTH,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  sm_ingress_narrow_adapter_if.slave bus,
  output logic [CNT_WIDTH-1:0]      stat_pkt_cnt,
  output logic [CNT_WIDTH-1:0]      stat_drop_cnt,
  output logic [CNT_WIDTH-1:0]      stat_err_cnt
);
  import sm_ingress_narrow_adapter_pkg::*;

  localparam int LW  = idx_w(IN_WIDTH / OUT_WIDTH);
  localparam int IEW = empty_w(IN_WIDTH);
  localparam int OEW = empty_w(OUT_WIDTH);
  localparam int GW  = idx_w(GAP_CYCLES + 1);

  typedef struct packed {
    logic [IN_WIDTH-1:0] data;
    logic                sop;
    logic                eop;
    logic [IEW-1:0]      empty;
  } beat_t;

  state_e                r_state;
  beat_t                 r_beat;
  logic                  r_full;
  logic [META_WIDTH-1:0] r_meta;
  logic [LW-1:0]         r_lane;
  logic [GW-1:0]         r_gap;
  logic [CNT_WIDTH-1:0]  r_pkt, r_drop, r_err;

  logic [OUT_WIDTH-1:0] w_lane_data;
  logic [LW-1:0]        w_last;
  logic [OEW-1:0]       w_pad;
  logic                 w_out_valid, w_cons, w_at_last, w_in_ready, w_acc, w_sop, w_eop;
  beat_t                w_in, w_cont;

  sm_lane_slicer #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_slicer (
    .i_data (r_beat.data),
    .i_eop  (r_beat.eop),
    .i_empty(r_beat.empty),
    .i_lane (r_lane),
    .o_data (w_lane_data),
    .o_last (w_last),
    .o_empty(w_pad)
  );

  assign w_out_valid = (r_state == ST_SEND) & r_full;
  assign w_cons      = w_out_valid & bus.out_ready;
  assign w_at_last   = (r_lane == w_last);
  assign w_in   = '{data: bus.in_data, sop: bus.in_sop, eop: bus.in_eop, empty: bus.in_empty};
  assign w_cont = '{data: bus.in_data, sop: 1'b0, eop: bus.in_eop, empty: bus.in_empty};

  // Refill while the last lane drains keeps full throughput across beats of one packet.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      ST_IDLE: w_in_ready = bus.in_meta_valid;
      ST_SEND: w_in_ready = !r_full | (w_cons & w_at_last & !r_beat.eop);
      default: w_in_ready = 1'b0;
    endcase
  end

  assign w_acc              = bus.in_valid & w_in_ready;
  assign bus.in_ready       = w_in_ready;
  assign bus.in_meta_ready  = (r_state == ST_IDLE) & w_acc & bus.in_sop;

  assign w_sop              = w_out_valid & r_beat.sop & (r_lane == '0);
  assign w_eop              = w_out_valid & r_beat.eop & w_at_last;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_data       = w_lane_data;
  assign bus.out_sop        = w_sop;
  assign bus.out_eop        = w_eop;
  assign bus.out_empty      = w_eop ? w_pad : '0;
  assign bus.out_meta_valid = w_sop;
  assign bus.out_meta_data  = r_meta;

  assign stat_pkt_cnt  = r_pkt;
  assign stat_drop_cnt = r_drop;
  assign stat_err_cnt  = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_full  <= 1'b0;
      r_meta  <= '0;
      r_lane  <= '0;
      r_gap   <= '0;
      r_pkt   <= '0;
      r_drop  <= '0;
      r_err   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            if (bus.in_sop) begin
              r_beat  <= w_in;
              r_full  <= 1'b1;
              r_lane  <= '0;
              r_meta  <= bus.in_meta_data;
              r_state <= ST_SEND;
            end else begin
              r_drop <= r_drop + CNT_WIDTH'(1);
            end
          end
        end
        ST_SEND: begin
          if (w_cons & w_at_last & r_beat.eop) begin
            r_full <= 1'b0;
            r_lane <= '0;
            r_pkt  <= r_pkt + CNT_WIDTH'(1);
            if (GAP_CYCLES == 0) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_GAP;
              r_gap   <= GW'(GAP_CYCLES - 1);
            end
          end else if (w_cons & !w_at_last) begin
            r_lane <= r_lane + LW'(1);
          end else if (w_acc) begin
            // A stray sop inside a packet is folded into the current packet.
            r_beat <= w_cont;
            r_full <= 1'b1;
            r_lane <= '0;
            if (bus.in_sop) r_err <= r_err + CNT_WIDTH'(1);
          end else if (w_cons) begin
            r_full <= 1'b0;
            r_lane <= '0;
          end
        end
        ST_GAP: begin
          if (r_gap == '0) r_state <= ST_IDLE;
          else             r_gap   <= r_gap - GW'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
